// File: rtl/conv3x3_relu_stream.sv
// Streaming 3x3 valid-region convolution with ReLU and requantisation.
// Pixels arrive row-major one per handshake; the whole (IMG_H-2)x(IMG_W-2)
// feature map is presented as one packed bus once the frame has drained.
module conv3x3_relu_stream #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int SHIFT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [3:0]                           in_pixel,
    input  logic [35:0]                          weights,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [4*(IMG_W-2)*(IMG_H-2)-1:0]     out_tile
);

    localparam int OW   = IMG_W - 2;
    localparam int OH   = IMG_H - 2;
    localparam int NOUT = OW * OH;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int IW   = $clog2(NOUT + 1);

    typedef enum logic [1:0] {FILL, FLUSH, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                flush_cnt_q, flush_cnt_d;
    logic [35:0]         w_q, w_d;
    logic [3:0]          lb0_q [IMG_W];   // row r-2
    logic [3:0]          lb0_d [IMG_W];
    logic [3:0]          lb1_q [IMG_W];   // row r-1
    logic [3:0]          lb1_d [IMG_W];
    logic [3:0]          win_q [3][2];    // columns c-2 (0) and c-1 (1)
    logic [3:0]          win_d [3][2];
    logic                s1_vld_q, s1_vld_d;
    logic signed [12:0]  s1_sum_q, s1_sum_d;
    logic [IW-1:0]       s1_idx_q, s1_idx_d;
    logic [4*NOUT-1:0]   out_tile_q, out_tile_d;

    logic                accept;
    logic                last_px;
    logic [3:0]          tap [9];
    logic signed [12:0]  mac_sum;

    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = (state_q == HOLD) && !rst;
    assign out_tile  = out_tile_q;
    assign accept    = in_valid && in_ready;
    assign last_px   = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    // Clip a MAC result: negative -> 0, else shift and saturate to 4 bits.
    function automatic logic [3:0] requant(input logic signed [12:0] s);
        logic [11:0] v;
        v = s[11:0] >> SHIFT;
        if (s[12])
            return 4'h0;
        return (v > 12'd15) ? 4'hF : v[3:0];
    endfunction

    // Assemble the full 3x3 window: two stored columns plus the incoming one.
    always_comb begin
        for (int kr = 0; kr < 3; kr++) begin
            tap[kr*3+0] = win_q[kr][0];
            tap[kr*3+1] = win_q[kr][1];
        end
        tap[2] = lb0_q[col_q];
        tap[5] = lb1_q[col_q];
        tap[8] = in_pixel;
    end

    // Multiply-accumulate over the window with the latched signed kernel.
    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < 9; k++)
            mac_sum = mac_sum + $signed({9'b0, tap[k]}) *
                                $signed({{9{w_q[4*k+3]}}, w_q[4*k +: 4]});
    end

    // Frame control: FILL accepts pixels, FLUSH drains two stages, HOLD presents.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (last_px) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = FLUSH;
                    end else if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q) begin
                    flush_cnt_d = 1'b0;
                    state_d     = HOLD;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Line buffers, window shift and kernel capture on each accepted pixel.
    always_comb begin
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        win_d = win_q;
        w_d   = w_q;
        if (accept) begin
            lb0_d[col_q] = lb1_q[col_q];
            lb1_d[col_q] = in_pixel;
            for (int kr = 0; kr < 3; kr++) begin
                win_d[kr][0] = win_q[kr][1];
                win_d[kr][1] = tap[kr*3+2];
            end
            if (row_q == '0 && col_q == '0)
                w_d = weights;
        end
    end

    // Stage 1 captures the sum and its map index; stage 2 writes the nibble.
    always_comb begin
        s1_vld_d   = 1'b0;
        s1_sum_d   = s1_sum_q;
        s1_idx_d   = s1_idx_q;
        out_tile_d = out_tile_q;
        if (accept && row_q >= RW'(2) && col_q >= CW'(2)) begin
            s1_vld_d = 1'b1;
            s1_sum_d = mac_sum;
            s1_idx_d = IW'((int'(row_q) - 2) * OW + int'(col_q) - 2);
        end
        if (s1_vld_q) begin
            for (int i = 0; i < NOUT; i++)
                if (s1_idx_q == IW'(i))
                    out_tile_d[4*i +: 4] = requant(s1_sum_q);
        end
    end

    // Control and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            flush_cnt_q <= 1'b0;
            w_q         <= '0;
            s1_vld_q    <= 1'b0;
            s1_sum_q    <= '0;
            s1_idx_q    <= '0;
            out_tile_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            flush_cnt_q <= flush_cnt_d;
            w_q         <= w_d;
            s1_vld_q    <= s1_vld_d;
            s1_sum_q    <= s1_sum_d;
            s1_idx_q    <= s1_idx_d;
            out_tile_q  <= out_tile_d;
        end
    end

    // Pixel storage; contents are always rewritten before being used.
    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
        win_q <= win_d;
    end

endmodule

// File: tb/tb_conv3x3_relu_stream.sv
// Bench for conv3x3_relu_stream: two instances (SHIFT=3 and SHIFT=0) share
// stimulus; results compared against a plain-arithmetic convolution model.
module tb_conv3x3_relu_stream;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [3:0]  in_pixel;
    logic [35:0] weights;
    logic        in_ready, in_ready0, out_valid, out_valid0;
    logic [63:0] out_tile, out_tile0;

    int          chk  = 0;
    int          fail = 0;
    logic [3:0]  fpx [36];

    always #5 clk = ~clk;

    conv3x3_relu_stream #(.IMG_W(6), .IMG_H(6), .SHIFT(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .weights(weights), .out_valid(out_valid),
        .out_ready(out_ready), .out_tile(out_tile)
    );

    conv3x3_relu_stream #(.IMG_W(6), .IMG_H(6), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pixel(in_pixel), .weights(weights), .out_valid(out_valid0),
        .out_ready(out_ready), .out_tile(out_tile0)
    );

    // Reference: direct 3x3 valid convolution, ReLU, shift, saturate.
    function automatic logic [63:0] model(input int sh, input logic [35:0] w);
        logic [63:0] t;
        logic [3:0]  wn;
        int          s, v;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        wn = w[4*(kr*3+kc) +: 4];
                        s += int'(fpx[(r+kr)*6 + c + kc]) * int'($signed(wn));
                    end
                v = (s < 0) ? 0 : (s >> sh);
                if (v > 15) v = 15;
                t[4*(r*4+c) +: 4] = 4'(v);
            end
        return t;
    endfunction

    function automatic logic [35:0] rand_w();
        return 36'({$urandom(), $urandom()});
    endfunction

    // Offer n pixels from fpx; weights switch to w1 once pixel 6 is reached.
    task automatic send_frame(input int n, input logic [35:0] w0,
                              input logic [35:0] w1, input bit gaps);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 4000) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_pixel = fpx[idx];
            weights  = (idx > 5) ? w1 : w0;
            if (in_valid && in_ready) idx++;
            guard++;
        end
        if (idx < n) begin
            chk++; fail++;
            $display("FAIL send_frame timeout accepted=%0d wanted=%0d", idx, n);
        end
    endtask

    // Count edges from the last accept until out_valid rises (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            cyc++;
        end
    endtask

    task automatic take_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0; weights = '0;
        repeat (2) @(negedge clk);
        chk++; if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin fail++;
            $display("FAIL reset_in_ready got=%b/%b exp=0", in_ready, in_ready0); end
        chk++; if (out_valid !== 1'b0) begin fail++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        chk++; if (out_tile !== 64'h0 || out_tile0 !== 64'h0) begin fail++;
            $display("FAIL reset_tile got=%h/%h exp=0", out_tile, out_tile0); end
        chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fail++;
            $display("FAIL reset_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_ones();
        int cyc;
        for (int i = 0; i < 36; i++) fpx[i] = 4'd1;
        send_frame(36, 36'h111111111, 36'h111111111, 1'b0);
        wait_out(cyc);
        chk++; if (cyc !== 2) begin fail++;
            $display("FAIL ones_latency got=%0d exp=2", cyc); end
        chk++; if (out_tile !== 64'h1111_1111_1111_1111) begin fail++;
            $display("FAIL ones_tile got=%h exp=1111111111111111", out_tile); end
        chk++; if (out_tile0 !== 64'h9999_9999_9999_9999) begin fail++;
            $display("FAIL ones_tile_sh0 got=%h exp=9999999999999999", out_tile0); end
        take_out();
        chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fail++;
            $display("FAIL ones_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_ramp();
        int cyc;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) fpx[r*6+c] = 4'(r + c);
        send_frame(36, 36'h000010000, 36'h000010000, 1'b1);
        wait_out(cyc);
        chk++; if (cyc !== 2) begin fail++;
            $display("FAIL ramp_latency got=%0d exp=2", cyc); end
        chk++; if (out_tile0[3:0] !== 4'd2 || out_tile0[63:60] !== 4'd8) begin fail++;
            $display("FAIL ramp_corners got=%h/%h exp=2/8", out_tile0[3:0], out_tile0[63:60]); end
        chk++; if (out_tile0 !== model(0, 36'h000010000)) begin fail++;
            $display("FAIL ramp_tile_sh0 got=%h exp=%h", out_tile0, model(0, 36'h000010000)); end
        chk++; if (out_tile !== model(3, 36'h000010000)) begin fail++;
            $display("FAIL ramp_tile got=%h exp=%h", out_tile, model(3, 36'h000010000)); end
        take_out();
    endtask

    task automatic test_relu();
        int cyc;
        for (int i = 0; i < 36; i++) fpx[i] = 4'($urandom_range(1, 15));
        send_frame(36, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0);
        wait_out(cyc);
        chk++; if (out_tile !== 64'h0 || out_tile0 !== 64'h0) begin fail++;
            $display("FAIL relu_tile got=%h/%h exp=0", out_tile, out_tile0); end
        take_out();
    endtask

    task automatic test_saturate();
        int cyc;
        for (int i = 0; i < 36; i++) fpx[i] = 4'd15;
        send_frame(36, 36'h777777777, 36'h777777777, 1'b1);
        wait_out(cyc);
        chk++; if (out_tile !== 64'hFFFF_FFFF_FFFF_FFFF || out_tile0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fail++;
            $display("FAIL sat_tile got=%h/%h exp=all F", out_tile, out_tile0); end
        take_out();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [35:0] w0, w1;
        logic [63:0] exp3;
        for (int i = 0; i < 36; i++) fpx[i] = 4'($urandom_range(0, 15));
        w0 = rand_w();
        exp3 = model(3, w0);
        send_frame(36, w0, w0, 1'b0);
        wait_out(cyc);
        chk++; if (cyc !== 2) begin fail++;
            $display("FAIL bp_latency got=%0d exp=2", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_pixel = 4'($urandom_range(0, 15));
            chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fail++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b exp=1/0", i, out_valid, in_ready); end
            chk++; if (out_tile !== exp3) begin fail++;
                $display("FAIL bp_tile cyc=%0d got=%h exp=%h", i, out_tile, exp3); end
        end
        in_valid = 1'b0;
        take_out();
        chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fail++;
            $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
        for (int i = 0; i < 36; i++) fpx[i] = 4'($urandom_range(0, 15));
        w0 = rand_w();
        w1 = ~w0;
        send_frame(36, w0, w1, 1'b1);
        wait_out(cyc);
        chk++; if (cyc !== 2) begin fail++;
            $display("FAIL bp2_latency got=%0d exp=2", cyc); end
        chk++; if (out_tile !== model(3, w0)) begin fail++;
            $display("FAIL bp2_tile got=%h exp=%h", out_tile, model(3, w0)); end
        chk++; if (out_tile0 !== model(0, w0)) begin fail++;
            $display("FAIL bp2_tile_sh0 got=%h exp=%h", out_tile0, model(0, w0)); end
        take_out();
    endtask

    task automatic test_random();
        int cyc;
        logic [35:0] w;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 36; i++) fpx[i] = 4'($urandom_range(0, 15));
            w = rand_w();
            send_frame(36, w, rand_w(), 1'b1);
            wait_out(cyc);
            chk++; if (out_tile !== model(3, w) || out_tile0 !== model(0, w)) begin fail++;
                $display("FAIL rand_tile f=%0d got=%h/%h exp=%h/%h", f, out_tile, out_tile0,
                         model(3, w), model(0, w)); end
            take_out();
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        for (int i = 0; i < 36; i++) fpx[i] = 4'($urandom_range(0, 15));
        send_frame(20, rand_w(), rand_w(), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fail++;
            $display("FAIL midrst_hold in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 36; i++) fpx[i] = 4'd1;
        send_frame(36, 36'h111111111, rand_w(), 1'b0);
        wait_out(cyc);
        chk++; if (cyc !== 2) begin fail++;
            $display("FAIL midrst_latency got=%0d exp=2", cyc); end
        chk++; if (out_tile !== 64'h1111_1111_1111_1111 || out_tile0 !== 64'h9999_9999_9999_9999) begin
            fail++;
            $display("FAIL midrst_tile got=%h/%h exp=1111111111111111/9999999999999999",
                     out_tile, out_tile0); end
        take_out();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_relu();
        test_saturate();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end

endmodule
